// File: rtl/shift_unit_ctrl.sv
// shift_unit_ctrl: sequencing and arbitration controller for the shared
// combinational 32-bit shifter in the miniRISC execute stage.
//
// Two requesters (req0 = ALU shift path, req1 = load/store byte alignment)
// share one shifter. One request is granted at a time. Its operands are
// latched, the shifter control lines are driven for one or two passes, and
// the result is returned on a valid/ready response port.
//
// Amounts of 32 or more run as two passes: a shift by 31, then a shift by 1.
// This gives 0 for SLL/SRL and sign fill for SRA.
//
// Optional build macro: SHIFT_CTRL_RR_ARB_EN
//   defined   -> round-robin arbitration with a 1-bit preference pointer
//   undefined -> fixed priority, req0 over req1
module shift_unit_ctrl #(
  parameter int DATA_W = 32,
  parameter int AMNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [1:0]        req0_type,
  input  logic [AMNT_W-1:0] req0_amnt,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [1:0]        req1_type,
  input  logic [AMNT_W-1:0] req1_amnt,
  // shared shifter
  output logic [DATA_W-1:0] sh_a,
  output logic [1:0]        sh_type,
  output logic [4:0]        sh_amnt,
  output logic              sh_enbl,
  input  logic [DATA_W-1:0] sh_out,
  // response
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS1 = 2'd1;
  localparam logic [1:0] ST_PASS2 = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] TYPE_RSVD = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;        // operand, reused for the pass-1 result
  logic [1:0]        type_q, type_d;
  logic [AMNT_W-1:0] amnt_q, amnt_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic grant0, grant1;
  logic accept;
  logic sel_id;
  logic big_amnt;

`ifdef SHIFT_CTRL_RR_ARB_EN
  logic ptr_q, ptr_d;                 // preferred requester when both are valid

  // Round-robin grant: the pointer breaks ties, a lone requester always wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant0 = !ptr_q;
      grant1 = ptr_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Pointer moves to the requester that was not granted on every accept.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = !sel_id;
  end

  // Pointer register; resets to prefer req0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`else
  // Fixed-priority grant: req0 wins whenever it is valid.
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid && !req0_valid;
  end
`endif

  // Readies only in IDLE so no accept overlaps an operation or a response.
  assign req0_ready = (state_q == ST_IDLE) && grant0;
  assign req1_ready = (state_q == ST_IDLE) && grant1;
  assign accept     = req0_ready || req1_ready;
  assign sel_id     = req1_ready;

  // Any bit at or above bit 5 set means the amount is 32 or more.
  assign big_amnt = |amnt_q[AMNT_W-1:5];

  // Next-state and datapath capture logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch; blocking '=' is correct here.
    state_d = state_q;
    a_d     = a_q;
    type_d  = type_q;
    amnt_d  = amnt_q;
    id_d    = id_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d    = sel_id ? req1_a    : req0_a;
          type_d = sel_id ? req1_type : req0_type;
          amnt_d = sel_id ? req1_amnt : req0_amnt;
          id_d   = sel_id;
          if ((sel_id ? req1_type : req0_type) == TYPE_RSVD) begin
            data_d  = sel_id ? req1_a : req0_a;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_PASS1;
          end
        end
      end
      ST_PASS1: begin
        if (big_amnt) begin
          a_d     = sh_out;
          state_d = ST_PASS2;
        end else begin
          data_d  = sh_out;
          state_d = ST_RESP;
        end
      end
      ST_PASS2: begin
        data_d  = sh_out;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and operand/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all registers here are plain flops (no memories), so each one is
    // reset; a reset mid-operation drops the in-flight request entirely.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      type_q  <= '0;
      amnt_q  <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking '<=' so every flop samples pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      type_q  <= type_d;
      amnt_q  <= amnt_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Shifter control lines; driven only during the two pass states.
  always_comb begin
    sh_enbl = 1'b0;
    sh_a    = '0;
    sh_type = 2'b00;
    sh_amnt = 5'd0;
    if (state_q == ST_PASS1) begin
      sh_enbl = 1'b1;
      sh_a    = a_q;
      sh_type = type_q;
      sh_amnt = big_amnt ? 5'd31 : amnt_q[4:0];
    end else if (state_q == ST_PASS2) begin
      sh_enbl = 1'b1;
      sh_a    = a_q;
      sh_type = type_q;
      sh_amnt = 5'd1;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_shift_unit_ctrl.sv
// Self-checking bench for shift_unit_ctrl: directed vectors with
// hand-computed expected results. A behavioural shifter model closes the
// loop on sh_* / sh_out. It returns a junk pattern while sh_enbl=0, so
// sampling outside a pass shows up as wrong data.
module tb_shift_unit_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a;
  logic [1:0]  req0_type;
  logic [7:0]  req0_amnt;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a;
  logic [1:0]  req1_type;
  logic [7:0]  req1_amnt;
  logic [31:0] sh_a;
  logic [1:0]  sh_type;
  logic [4:0]  sh_amnt;
  logic        sh_enbl;
  logic [31:0] sh_out;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;

  int n_cmp = 0;
  int n_err = 0;

  shift_unit_ctrl #(.DATA_W(32), .AMNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_type(req0_type), .req0_amnt(req0_amnt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_type(req1_type), .req1_amnt(req1_amnt),
    .sh_a(sh_a), .sh_type(sh_type), .sh_amnt(sh_amnt), .sh_enbl(sh_enbl),
    .sh_out(sh_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational shifter model.
  always_comb begin
    if (sh_enbl) begin
      case (sh_type)
        2'b00:   sh_out = sh_a << sh_amnt;
        2'b01:   sh_out = sh_a >> sh_amnt;
        2'b10:   sh_out = $signed(sh_a) >>> sh_amnt;
        default: sh_out = sh_a;
      endcase
    end else begin
      sh_out = 32'h5A5A_5A5A;
    end
  end

  // Present a request on one port and hold it until it is accepted.
  // Returns at accept edge + 1.
  task automatic send(input bit id, input logic [31:0] a, input logic [1:0] t,
                      input logic [7:0] amnt);
    int w;
    w = 0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_type = t; req1_amnt = amnt;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_type = t; req0_amnt = amnt;
    end
    #1;
    while (!(id ? req1_ready : req0_ready) && w < 20) begin
      @(posedge clk); #1; w++;
    end
    n_cmp++;
    if (w >= 20) begin
      n_err++; $display("FAIL accept_timeout id=%0d waited=%0d required<20", id, w);
    end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // From accept edge + 1, wait for rsp_valid. Latency is counted in edges
  // after accept. Shifter passes seen on the way are recorded.
  task automatic wait_rsp(output int cyc, output int pulses,
                          output logic [4:0] am1, output logic [4:0] am2,
                          output logic [31:0] sa1, output logic [1:0] st1);
    cyc = 1; pulses = 0; am1 = '0; am2 = '0; sa1 = '0; st1 = '0;
    while (!rsp_valid && cyc < 20) begin
      if (sh_enbl) begin
        if (pulses == 0) begin am1 = sh_amnt; sa1 = sh_a; st1 = sh_type; end
        else am2 = sh_amnt;
        pulses++;
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  // Accept the pending response (one cycle of rsp_ready).
  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({req0_ready, req1_ready, sh_enbl, sh_a, sh_type, sh_amnt, rsp_valid, rsp_id, rsp_data, rsp_err} !== '0) begin
      n_err++; $display("FAIL reset_outputs got sh_enbl=%b sh_a=%h rsp_valid=%b rsp_data=%h required all 0", sh_enbl, sh_a, rsp_valid, rsp_data);
    end
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b1; #1;
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++; $display("FAIL idle_ready_req0 got r0=%b r1=%b required r0=1 r1=0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b1; #1;
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      n_err++; $display("FAIL idle_ready_req1 got r0=%b r1=%b required r0=0 r1=1", req0_ready, req1_ready);
    end
    req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [1:0]  t;
    logic [7:0]  amnt;
    logic [31:0] exp;
    int          lat;
    int          pulses;
    logic [4:0]  am1;
    logic [4:0]  am2;
  } vec_t;

  task automatic test_shift_vectors();
    vec_t v[8];
    int cyc, pulses;
    logic [4:0] am1, am2;
    logic [31:0] sa1;
    logic [1:0] st1;
    v[0] = '{1'b0, 32'd11,         2'd0, 8'd2,   32'd44,         2, 1, 5'd2,  5'd0};
    v[1] = '{1'b1, 32'h8000_0010,  2'd2, 8'd40,  32'hFFFF_FFFF,  3, 2, 5'd31, 5'd1};
    v[2] = '{1'b1, 32'h8000_0010,  2'd1, 8'd40,  32'h0000_0000,  3, 2, 5'd31, 5'd1};
    v[3] = '{1'b1, 32'hDEAD_BEEF,  2'd0, 8'd0,   32'hDEAD_BEEF,  2, 1, 5'd0,  5'd0};
    v[4] = '{1'b0, 32'h8000_0000,  2'd2, 8'd31,  32'hFFFF_FFFF,  2, 1, 5'd31, 5'd0};
    v[5] = '{1'b0, 32'hFFFF_FFFF,  2'd1, 8'd32,  32'h0000_0000,  3, 2, 5'd31, 5'd1};
    v[6] = '{1'b1, 32'h0000_ABCD,  2'd0, 8'd255, 32'h0000_0000,  3, 2, 5'd31, 5'd1};
    v[7] = '{1'b0, 32'hF000_0000,  2'd1, 8'd8,   32'h00F0_0000,  2, 1, 5'd8,  5'd0};
    for (int i = 0; i < 8; i++) begin
      send(v[i].id, v[i].a, v[i].t, v[i].amnt);
      wait_rsp(cyc, pulses, am1, am2, sa1, st1);
      n_cmp++;
      if (cyc !== v[i].lat) begin
        n_err++; $display("FAIL vec%0d_latency got=%0d required=%0d", i, cyc, v[i].lat);
      end
      n_cmp++;
      if (pulses !== v[i].pulses || am1 !== v[i].am1 || am2 !== v[i].am2) begin
        n_err++; $display("FAIL vec%0d_passes got pulses=%0d amnts=%0d,%0d required pulses=%0d amnts=%0d,%0d", i, pulses, am1, am2, v[i].pulses, v[i].am1, v[i].am2);
      end
      n_cmp++;
      if (sa1 !== v[i].a || st1 !== v[i].t) begin
        n_err++; $display("FAIL vec%0d_pass1_ctrl got sh_a=%h sh_type=%0d required sh_a=%h sh_type=%0d", i, sa1, st1, v[i].a, v[i].t);
      end
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== v[i].exp || rsp_id !== v[i].id || rsp_err !== 1'b0) begin
        n_err++; $display("FAIL vec%0d_rsp got valid=%b data=%h id=%b err=%b required valid=1 data=%h id=%b err=0", i, rsp_valid, rsp_data, rsp_id, rsp_err, v[i].exp, v[i].id);
      end
      consume();
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL vec%0d_rsp_clear got valid=%b required 0", i, rsp_valid);
      end
    end
  endtask

  task automatic test_reserved();
    int cyc, pulses;
    logic [4:0] am1, am2;
    logic [31:0] sa1;
    logic [1:0] st1;
    send(1'b0, 32'h0000_1234, 2'b11, 8'd5);
    wait_rsp(cyc, pulses, am1, am2, sa1, st1);
    n_cmp++;
    if (cyc !== 1 || pulses !== 0) begin
      n_err++; $display("FAIL rsvd_timing got latency=%0d pulses=%0d required latency=1 pulses=0", cyc, pulses);
    end
    n_cmp++;
    if (rsp_data !== 32'h0000_1234 || rsp_err !== 1'b1 || rsp_id !== 1'b0) begin
      n_err++; $display("FAIL rsvd_rsp got data=%h err=%b id=%b required data=00001234 err=1 id=0", rsp_data, rsp_err, rsp_id);
    end
    consume();
    n_cmp++;
    if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL rsvd_clear got err=%b valid=%b required err=0 valid=0", rsp_err, rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    int cyc, pulses;
    logic [4:0] am1, am2;
    logic [31:0] sa1;
    logic [1:0] st1;
    bit bad;
    send(1'b0, 32'h0000_00F0, 2'd1, 8'd4);
    wait_rsp(cyc, pulses, am1, am2, sa1, st1);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_000F) begin
      n_err++; $display("FAIL bp_first got valid=%b data=%h required valid=1 data=0000000f", rsp_valid, rsp_data);
    end
    req0_valid = 1'b1; req0_type = 2'd0; req0_amnt = 8'd0;
    req1_valid = 1'b1; req1_type = 2'd0; req1_amnt = 8'd0;
    #1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_000F || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || sh_enbl !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad) begin
      n_err++; $display("FAIL bp_hold got valid=%b data=%h id=%b r0=%b r1=%b sh_enbl=%b required valid=1 data=0000000f id=0 r0=0 r1=0 sh_enbl=0", rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready, sh_enbl);
    end
    req0_valid = 1'b0;
    consume();
    n_cmp++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_release got valid=%b r0=%b r1=%b required valid=0 r0=0 r1=1", rsp_valid, req0_ready, req1_ready);
    end
    req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous();
    int cyc, pulses;
    logic [4:0] am1, am2;
    logic [31:0] sa1;
    logic [1:0] st1;
    logic        exp_id2;
    logic [31:0] exp_data2;
`ifdef SHIFT_CTRL_RR_ARB_EN
    exp_id2 = 1'b1; exp_data2 = 32'h0000_0010;
`else
    exp_id2 = 1'b0; exp_data2 = 32'h0000_0010 << 0 | 32'd16;
`endif
    apply_reset();
    req0_valid = 1'b1; req0_a = 32'd1;        req0_type = 2'd0; req0_amnt = 8'd4;
    req1_valid = 1'b1; req1_a = 32'h0000_0100; req1_type = 2'd1; req1_amnt = 8'd4;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_err++; $display("FAIL sim_grant1 got r0=%b r1=%b required r0=1 r1=0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    wait_rsp(cyc, pulses, am1, am2, sa1, st1);
    n_cmp++;
    if (rsp_id !== 1'b0 || rsp_data !== 32'd16) begin
      n_err++; $display("FAIL sim_rsp1 got id=%b data=%h required id=0 data=00000010", rsp_id, rsp_data);
    end
    consume();
    n_cmp++;
    if (req0_ready !== !exp_id2 || req1_ready !== exp_id2) begin
      n_err++; $display("FAIL sim_grant2 got r0=%b r1=%b required r0=%b r1=%b", req0_ready, req1_ready, !exp_id2, exp_id2);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(cyc, pulses, am1, am2, sa1, st1);
    n_cmp++;
    if (rsp_id !== exp_id2 || rsp_data !== exp_data2) begin
      n_err++; $display("FAIL sim_rsp2 got id=%b data=%h required id=%b data=%h", rsp_id, rsp_data, exp_id2, exp_data2);
    end
    consume();
  endtask

  task automatic test_reset_midop();
    bit bad;
    send(1'b0, 32'h1234_5678, 2'd0, 8'd40);
    n_cmp++;
    if (sh_enbl !== 1'b1 || sh_amnt !== 5'd31) begin
      n_err++; $display("FAIL midop_pass1 got sh_enbl=%b sh_amnt=%0d required sh_enbl=1 sh_amnt=31", sh_enbl, sh_amnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready, sh_enbl, sh_a, sh_type, sh_amnt, rsp_valid, rsp_id, rsp_data, rsp_err} !== '0) begin
      n_err++; $display("FAIL midop_async_reset got sh_enbl=%b sh_a=%h sh_amnt=%0d rsp_valid=%b rsp_data=%h required all 0", sh_enbl, sh_a, sh_amnt, rsp_valid, rsp_data);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || sh_enbl !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++; $display("FAIL midop_no_rsp got rsp_valid=%b sh_enbl=%b required 0 and 0", rsp_valid, sh_enbl);
    end
    req0_valid = 1'b1; #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_err++; $display("FAIL midop_idle got r0=%b required 1", req0_ready);
    end
    req0_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_type = '0; req0_amnt = '0;
    req1_valid = 1'b0; req1_a = '0; req1_type = '0; req1_amnt = '0;
    test_reset();
    test_shift_vectors();
    test_reserved();
    test_backpressure();
    test_simultaneous();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
